io_uart_bridge: RTL

IO_UART_BRIDGE -- requirements
Module: io_uart_bridge

---
 rtl/io_uart_pkg.sv | 14 +
 rtl/io_byte_fifo.sv | 38 +++
 rtl/io_uart_bridge.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/io_uart_pkg.sv
// io_uart_pkg: port offsets, status bit positions and FSM encodings for the IO UART bridge.
package io_uart_pkg;
  localparam logic [7:0] PORT_TX = 8'd0;
  localparam logic [7:0] PORT_RX = 8'd1;
  localparam logic [7:0] PORT_STATUS = 8'd2;
  localparam int ST_TX_FULL = 0;
  localparam int ST_TX_IDLE = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_FULL = 3;
  localparam int ST_TX_OVR = 4;
  localparam int ST_RX_OVR = 5;
  localparam int ST_FRAME_ERR = 6;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
endpackage

// File: rtl/io_byte_fifo.sv
// io_byte_fifo: synchronous byte FIFO; a push while full is rejected even alongside a pop.
module io_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      if (do_push && !do_pop) cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/io_uart_bridge.sv
// io_uart_bridge: 8N1 UART behind three processor IO ports (TX data, RX data, status).
module io_uart_bridge import io_uart_pkg::*; #(
  parameter int CLK_DIV = 868,
  parameter int FIFO_DEPTH = 8,
  parameter logic [7:0] BASE_ID = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IO_port_ID,
  input  logic [7:0] IO_write_data,
  input  logic       IO_write_strobe,
  input  logic       IO_read_strobe,
  output logic [7:0] IO_read_data,
  output logic       uart_txd,
  input  logic       uart_rxd
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [7:0] ID_TX = BASE_ID + PORT_TX;
  localparam logic [7:0] ID_RX = BASE_ID + PORT_RX;
  localparam logic [7:0] ID_ST = BASE_ID + PORT_STATUS;
  uart_state_t tx_state, rx_state;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_bit, rx_bit;
  logic [7:0] tx_shift, rx_shift, tx_head, rx_head, status;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic rx_s0, rxs, rx_prev, tx_ovr, rx_ovr, frame_err;
  logic wr_tx, rd_rx, rd_st, tx_pop, tx_tick, rx_tick, rx_push, rx_bad;
  assign wr_tx = IO_write_strobe && IO_port_ID == ID_TX;
  assign rd_rx = IO_read_strobe && IO_port_ID == ID_RX;
  assign rd_st = IO_read_strobe && IO_port_ID == ID_ST;
  assign tx_pop = tx_state == S_IDLE && !tx_empty;
  assign tx_tick = tx_cnt == CW'(CLK_DIV - 1);
  assign rx_tick = rx_cnt == CW'(CLK_DIV - 1);
  assign rx_push = rx_state == S_STOP && rx_tick && rxs;
  assign rx_bad = rx_state == S_STOP && rx_tick && !rxs;
  io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(wr_tx), .pop(tx_pop), .din(IO_write_data),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );
  io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rd_rx), .din(rx_shift),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );
  always_comb begin
    status = '0;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_IDLE] = tx_empty && tx_state == S_IDLE;
    status[ST_RX_VALID] = !rx_empty;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_OVR] = tx_ovr;
    status[ST_RX_OVR] = rx_ovr;
    status[ST_FRAME_ERR] = frame_err;
  end
  assign IO_read_data = IO_port_ID == ID_RX ? (rx_empty ? 8'h00 : rx_head) :
                        IO_port_ID == ID_ST ? status : 8'h00;
  // A new event wins over a same-cycle status-read clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovr <= 1'b0;
      rx_ovr <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_ovr <= (wr_tx && tx_full) || (tx_ovr && !rd_st);
      rx_ovr <= (rx_push && rx_full) || (rx_ovr && !rd_st);
      frame_err <= rx_bad || (frame_err && !rd_st);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else if (tx_state == S_IDLE) begin
      if (!tx_empty) begin
        tx_state <= S_START;
        tx_shift <= tx_head;
        tx_cnt <= '0;
        uart_txd <= 1'b0;
      end
    end else if (!tx_tick) tx_cnt <= tx_cnt + 1'b1;
    else begin
      tx_cnt <= '0;
      case (tx_state)
        S_START: begin
          tx_state <= S_DATA;
          tx_bit <= '0;
          uart_txd <= tx_shift[0];
        end
        S_DATA: if (tx_bit == 3'd7) begin
          tx_state <= S_STOP;
          uart_txd <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 1'b1;
          tx_shift <= tx_shift >> 1;
          uart_txd <= tx_shift[1];
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end
  // The start bit is confirmed half a bit after the edge, so later samples land mid-bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s0 <= 1'b1;
      rxs <= 1'b1;
      rx_prev <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_shift <= '0;
    end else begin
      rx_s0 <= uart_rxd;
      rxs <= rx_s0;
      rx_prev <= rxs;
      case (rx_state)
        S_IDLE: if (rx_prev && !rxs) begin
          rx_state <= S_START;
          rx_cnt <= '0;
        end
        S_START: if (rx_cnt == CW'(CLK_DIV / 2 - 1)) begin
          rx_state <= rxs ? S_IDLE : S_DATA;
          rx_cnt <= '0;
          rx_bit <= '0;
        end else rx_cnt <= rx_cnt + 1'b1;
        S_DATA: if (rx_tick) begin
          rx_shift <= {rxs, rx_shift[7:1]};
          rx_cnt <= '0;
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= S_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: if (rx_tick) begin
          rx_state <= S_IDLE;
          rx_cnt <= '0;
        end else rx_cnt <= rx_cnt + 1'b1;
      endcase
    end
  end
endmodule
